pr_dma: RTL
===========

# pr_dma

Memory-mapped DMA initiator for the processor-peripheral (Pr) bus. It is the bus-master counterpart of the timer-style responders. The CPU programs it through the bridge like any other device: a timer-compatible 2-bit register port. Once started, it drives its own address / write-data / write-enable onto the Pr bus, arbitrated against the CPU by req/gnt, and copies COUNT words from SRC to DST. It raises IRQ on completion.

## Interface
- No parameters; widths fixed (32-bit data/address, 16-bit effective count).
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- addr  in  2  register select [3:2] from bridge: 0 CTRL, 1 SRC, 2 DST, 3 COUNT
- we  in  1  register write enable from bridge
- data_in  in  32  register write data (Pr_WD)
- data_out  out  32  register read data, combinational on addr
- IRQ  out  1  interrupt, level: CTRL.done & CTRL.im
- m_req  out  1  bus request; high in READ and WRITE states
- m_gnt  in  1  bus grant; a beat completes on a rising edge with m_req & m_gnt
- m_addr  out  32  master address; SRC in READ, DST in WRITE, 0 otherwise
- m_we  out  1  master write enable; high only in WRITE
- m_wd  out  32  master write data = word buffer
- m_rd  in  32  master read data; combinational from bridge in the same cycle

## Operation
- CTRL bits:
  - [0] start/busy: write 1 in IDLE starts a transfer; reads 1 while not IDLE.
  - [1] im: interrupt mask.
  - [2] done: sticky; write 0 clears it.
  - [31:3] read 0.
- SRC/DST: bits [1:0] forced 0 on write. Read back the current (advancing) pointer.
- COUNT: [15:0] used, [31:16] read 0. Decrements per completed word.
- SRC, DST and COUNT writes are ignored while busy. CTRL.im is always writable.
- FSM states IDLE, READ, WRITE, DONE; encoding 2 bits, IDLE=0.
  - IDLE: CTRL write with bit0=1 sets done=0. Then COUNT==0 → DONE, else → READ.
  - READ: on m_gnt, buf ← m_rd and go to WRITE. Without grant, hold all outputs stable.
  - WRITE: on m_gnt, the write is accepted. SRC += 4, DST += 4, COUNT −= 1. If the old COUNT was 1 → DONE, else → READ.
  - DONE: done ← 1, → IDLE.
- Abort: a CTRL write with bit0=0 in READ/WRITE returns to IDLE next edge. done stays 0; pointers and COUNT keep their current values.
- Pointer wrap: SRC/DST wrap modulo 2^32 silently.
- A same-cycle CTRL write and DONE→IDLE: DONE sets done=1 and the write is interpreted in DONE, i.e. ignored except for im.
- Reset values: all registers 0, state IDLE, buf 0. Outputs: IRQ=0, m_req=0, m_we=0, m_addr=0, m_wd=0, data_out=0 (addr is 0 → CTRL=0).

## Timing
- Start write at edge E0; READ begins the following cycle.
- With m_gnt tied 1: one word takes 2 cycles. N words reach DONE at edge E(2N), and done/IRQ go high after edge E(2N+1).
- Each withheld m_gnt cycle adds exactly one cycle. m_addr, m_we and m_wd never change while waiting.
- m_we is never asserted in the same cycle as a READ beat. m_req drops in the DONE cycle.
- data_out is combinational from registers, so readback has zero-cycle latency.
- The bridge decodes m_addr in the same cycle as the beat. m_rd is sampled only on the granting edge.

## Structure
- Shared package pr_dma_pkg: state encoding, register offsets (CTRL/SRC/DST/COUNT), CTRL bit indices (BUSY=0, IM=1, DONE=2).
- One sub-module, pr_dma_regs: register file, write masking, read mux and IRQ generation. It receives pointer/count update strobes and the done-set strobe from the FSM.
- Top pr_dma holds the FSM, buf and master-port muxing.

## Test plan
- Reset mid-transfer: assert reset in WRITE → next cycle all outputs 0, state IDLE, COUNT readback 0.
- Basic copy: SRC=0x100, DST=0x200, COUNT=3, im=1, m_gnt=1, start.
  - Beats: reads 0x100/0x104/0x108, writes to 0x200/0x204/0x208 with matching data.
  - IRQ rises 7 cycles after the start edge.
  - Readback: SRC=0x10C, DST=0x20C, COUNT=0.
- Grant stall: same setup with m_gnt low for 3 cycles during the word-1 WRITE → m_addr=0x204, m_we=1 and m_wd held stable. Done is delayed by exactly 3 cycles.
- Zero count: COUNT=0, start → no m_req ever asserted; done=1 after 2 edges. IRQ=0 when im=0 and becomes 1 when im is set later.
- Abort and lockout:
  - Start with COUNT=5, write SRC=0xFFF during READ → write ignored.
  - Write CTRL=0 after 2 words → IDLE, done=0, COUNT readback 3, no IRQ.
- Done clear and restart: after completion write CTRL=0x2 → IRQ drops. Write CTRL=0x3 → second transfer runs and done re-asserts.

Source files
------------

// File: rtl/pr_dma_pkg.sv
// Shared definitions for the Pr-bus DMA initiator: FSM encoding, register map,
// CTRL bit positions and small helpers.
package pr_dma_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] REG_CTRL  = 2'd0;
  localparam logic [ADDR_W-1:0] REG_SRC   = 2'd1;
  localparam logic [ADDR_W-1:0] REG_DST   = 2'd2;
  localparam logic [ADDR_W-1:0] REG_COUNT = 2'd3;

  localparam int unsigned CTRL_BUSY = 0;
  localparam int unsigned CTRL_IM   = 1;
  localparam int unsigned CTRL_DONE = 2;

  localparam logic [DATA_W-1:0] PTR_STEP = 32'd4;

  // Pointers are word aligned; the low two bits never hold state.
  function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] a);
    return {a[DATA_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pr_dma_regs.sv
// Register file for pr_dma: CTRL/SRC/DST/COUNT storage, write lockout while a
// transfer is in flight, combinational readback and IRQ generation.
module pr_dma_regs
  import pr_dma_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                we,
  input  logic [DATA_W-1:0]   data_in,
  input  state_t              state,
  input  logic                advance,
  input  logic                set_done,
  output logic [DATA_W-1:0]   data_out,
  output logic                irq,
  output logic [DATA_W-1:0]   src,
  output logic [DATA_W-1:0]   dst,
  output logic [CNT_W-1:0]    count
);

  logic im;
  logic done;
  logic idle;
  logic ctrl_wr;
  logic done_clr;

  assign idle    = (state == ST_IDLE);
  assign ctrl_wr = we && (addr == REG_CTRL);

  // done is cleared by writing 0 to it, or implicitly by a start from IDLE;
  // a CTRL write landing in the DONE cycle only updates im.
  assign done_clr = ctrl_wr && (state != ST_DONE) &&
                    (!data_in[CTRL_DONE] || (idle && data_in[CTRL_BUSY]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im    <= 1'b0;
      done  <= 1'b0;
      src   <= '0;
      dst   <= '0;
      count <= '0;
    end else begin
      if (ctrl_wr) begin
        im <= data_in[CTRL_IM];
      end

      if (set_done) begin
        done <= 1'b1;
      end else if (done_clr) begin
        done <= 1'b0;
      end

      // Pointer/count writes only land while idle, so they never race advance.
      if (advance) begin
        src   <= src + PTR_STEP;
        dst   <= dst + PTR_STEP;
        count <= count - 16'd1;
      end else if (we && idle) begin
        case (addr)
          REG_SRC:   src   <= word_align(data_in);
          REG_DST:   dst   <= word_align(data_in);
          REG_COUNT: count <= data_in[CNT_W-1:0];
          default:   ;
        endcase
      end
    end
  end

  // Zero-latency readback, selected purely by addr.
  always_comb begin
    data_out = '0;
    case (addr)
      REG_CTRL: begin
        data_out[CTRL_BUSY] = !idle;
        data_out[CTRL_IM]   = im;
        data_out[CTRL_DONE] = done;
      end
      REG_SRC:   data_out = src;
      REG_DST:   data_out = dst;
      REG_COUNT: data_out = {16'd0, count};
      default:   data_out = '0;
    endcase
  end

  assign irq = done & im;

endmodule

// File: rtl/pr_dma.sv
// Pr-bus DMA initiator: copies COUNT words from SRC to DST through a req/gnt
// arbitrated master port, one read beat then one write beat per word.
module pr_dma
  import pr_dma_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                we,
  input  logic [DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]   data_out,
  output logic                IRQ,
  output logic                m_req,
  input  logic                m_gnt,
  output logic [DATA_W-1:0]   m_addr,
  output logic                m_we,
  output logic [DATA_W-1:0]   m_wd,
  input  logic [DATA_W-1:0]   m_rd
);

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] word_buf;
  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] dst;
  logic [CNT_W-1:0]  count;
  logic              ctrl_wr;
  logic              start;
  logic              abort;
  logic              load_buf;
  logic              advance;
  logic              set_done;

  assign ctrl_wr = we && (addr == REG_CTRL);
  assign start   = ctrl_wr && data_in[CTRL_BUSY];
  assign abort   = ctrl_wr && !data_in[CTRL_BUSY];

  pr_dma_regs u_regs (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .we       (we),
    .data_in  (data_in),
    .state    (state),
    .advance  (advance),
    .set_done (set_done),
    .data_out (data_out),
    .irq      (IRQ),
    .src      (src),
    .dst      (dst),
    .count    (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      word_buf <= '0;
    end else begin
      state <= state_nx;
      if (load_buf) begin
        word_buf <= m_rd;
      end
    end
  end

  // Abort takes priority over a same-cycle grant so pointers stay put.
  always_comb begin
    state_nx = state;
    load_buf = 1'b0;
    advance  = 1'b0;
    set_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = (count == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (m_gnt) begin
          load_buf = 1'b1;
          state_nx = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (m_gnt) begin
          advance  = 1'b1;
          state_nx = (count == 16'd1) ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: begin
        set_done = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Master port is a pure function of state and registers, so it holds
  // steady for as long as the grant is withheld.
  always_comb begin
    m_req  = 1'b0;
    m_we   = 1'b0;
    m_addr = '0;
    case (state)
      ST_READ: begin
        m_req  = 1'b1;
        m_addr = src;
      end
      ST_WRITE: begin
        m_req  = 1'b1;
        m_we   = 1'b1;
        m_addr = dst;
      end
      default: ;
    endcase
  end

  assign m_wd = word_buf;

endmodule
